// File: rtl/pad_mux_cfg_sequencer.sv
// pad_mux_cfg_sequencer
//   Serialises pad-mux reconfiguration requests for the IO ring. Requesters are
//   arbitrated round-robin. A request whose select equals the pad's current
//   select only updates OE (fast path). A request that changes the select runs
//   a glitch-free sequence: OE low, wait SETTLE_CYCLES, switch select, then
//   restore the requested OE. Pads flagged in LOCK_MASK, and indices outside
//   the ring, are accepted but rejected with a one-cycle err_o pulse.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester request valid
//   req_ready_o  per-requester accept (combinational, only in IDLE)
//   req_pad_i    per-requester pad index, requester k in slice k
//   req_sel_i    per-requester new mux select
//   req_oe_i     per-requester new output enable
//   pad_sel_o    per-pad mux select (registered)
//   pad_oe_o     per-pad output enable (registered)
//   busy_o       high while a select-changing sequence is in flight
//   err_o        one-cycle pulse after a rejected request
//   dbg_state_o  current sequencer state, for observation only
//
// Handshake: a request on requester k transfers on the rising edge where
// req_valid_i[k] && req_ready_o[k]. Ready is asserted for at most one
// requester, only in IDLE, and does not depend on ready from anywhere else.
// A requester that is not granted must hold valid and its data stable.
module pad_mux_cfg_sequencer #(
    parameter int              N_IO          = 48,
    parameter int              N_REQ         = 2,
    parameter int              SEL_W         = 2,
    parameter int              IDX_W         = 6,
    parameter int              SETTLE_CYCLES = 4,
    parameter logic [N_IO-1:0] LOCK_MASK     = 48'h140
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*IDX_W-1:0]   req_pad_i,
    input  logic [N_REQ*SEL_W-1:0]   req_sel_i,
    input  logic [N_REQ-1:0]         req_oe_i,
    output logic [N_IO*SEL_W-1:0]    pad_sel_o,
    output logic [N_IO-1:0]          pad_oe_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [2:0]               dbg_state_o
);

    localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GATE   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_APPLY  = 3'd3;
    localparam logic [2:0] ST_ENABLE = 3'd4;

    logic [2:0]            state_q;
    logic [RR_W-1:0]       rr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      tgt_q;
    logic [SEL_W-1:0]      tgt_sel_q;
    logic                  tgt_oe_q;
    logic [N_IO*SEL_W-1:0] sel_q;
    logic [N_IO-1:0]       oe_q;
    logic                  err_q;

    logic                  grant_vld;
    logic [RR_W-1:0]       grant_idx;
    logic [RR_W-1:0]       rr_next;
    logic                  accept;
    logic [IDX_W-1:0]      acc_pad;
    logic [SEL_W-1:0]      acc_sel;
    logic                  acc_oe;
    logic                  acc_in_range;
    logic                  acc_locked;
    logic [SEL_W-1:0]      acc_cur_sel;
    logic [N_IO-1:0]       acc_hit;
    logic [N_IO-1:0]       tgt_hit;
    logic [N_IO*SEL_W-1:0] sel_applied;

    // Round-robin: first valid requester at or after rr_q, then wrap to the
    // ones below rr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_vld && req_valid_i[k] && (k >= int'(rr_q))) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(k);
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_vld && req_valid_i[k] && (k < int'(rr_q))) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(k);
            end
        end
    end

    assign accept  = (state_q == ST_IDLE) && grant_vld;
    assign rr_next = (grant_idx == RR_W'(N_REQ - 1)) ? '0 : grant_idx + RR_W'(1);

    always_comb begin
        req_ready_o = '0;
        acc_pad     = '0;
        acc_sel     = '0;
        acc_oe      = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == RR_W'(k)) begin
                req_ready_o[k] = accept;
                acc_pad        = req_pad_i[k*IDX_W +: IDX_W];
                acc_sel        = req_sel_i[k*SEL_W +: SEL_W];
                acc_oe         = req_oe_i[k];
            end
        end
    end

    // Pad decode by full-width compare: an index that matches no pad is out
    // of range, so upper index bits can never alias onto a real pad.
    always_comb begin
        acc_in_range = 1'b0;
        acc_locked   = 1'b0;
        acc_cur_sel  = '0;
        acc_hit      = '0;
        tgt_hit      = '0;
        sel_applied  = sel_q;
        for (int i = 0; i < N_IO; i++) begin
            if (acc_pad == IDX_W'(i)) begin
                acc_in_range = 1'b1;
                acc_locked   = LOCK_MASK[i];
                acc_cur_sel  = sel_q[i*SEL_W +: SEL_W];
                acc_hit[i]   = 1'b1;
            end
            if (tgt_q == IDX_W'(i)) begin
                tgt_hit[i]                   = 1'b1;
                sel_applied[i*SEL_W +: SEL_W] = tgt_sel_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            cnt_q     <= '0;
            tgt_q     <= '0;
            tgt_sel_q <= '0;
            tgt_oe_q  <= 1'b0;
            sel_q     <= '0;
            oe_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rr_q      <= rr_next;
                        tgt_q     <= acc_pad;
                        tgt_sel_q <= acc_sel;
                        tgt_oe_q  <= acc_oe;
                        cnt_q     <= CNT_LOAD;
                        if (!acc_in_range || acc_locked) begin
                            err_q <= 1'b1;
                        end else if (acc_sel == acc_cur_sel) begin
                            oe_q <= (oe_q & ~acc_hit) | (acc_oe ? acc_hit : '0);
                        end else begin
                            oe_q    <= oe_q & ~acc_hit;
                            state_q <= ST_GATE;
                        end
                    end
                end
                // GATE is the first OE-low cycle and already counts toward the
                // settle time; with SETTLE_CYCLES=1 it switches the select itself.
                ST_GATE: begin
                    if (cnt_q == '0) begin
                        sel_q   <= sel_applied;
                        state_q <= ST_ENABLE;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                        state_q <= (cnt_q == CNT_W'(1)) ? ST_APPLY : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    sel_q   <= sel_applied;
                    state_q <= ST_ENABLE;
                end
                ST_ENABLE: begin
                    oe_q    <= (oe_q & ~tgt_hit) | (tgt_oe_q ? tgt_hit : '0);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pad_sel_o   = sel_q;
    assign pad_oe_o    = oe_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pad_mux_cfg_sequencer.sv
module tb_pad_mux_cfg_sequencer;

    localparam int N_IO   = 48;
    localparam int N_REQ  = 2;
    localparam int SEL_W  = 2;
    localparam int IDX_W  = 6;
    localparam int SETTLE = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b1;
    logic [N_REQ-1:0]       req_valid_i = '0;
    logic [N_REQ-1:0]       req_ready_o;
    logic [N_REQ*IDX_W-1:0] req_pad_i = '0;
    logic [N_REQ*SEL_W-1:0] req_sel_i = '0;
    logic [N_REQ-1:0]       req_oe_i = '0;
    logic [N_IO*SEL_W-1:0]  pad_sel_o;
    logic [N_IO-1:0]        pad_oe_o;
    logic                   busy_o;
    logic                   err_o;
    logic [2:0]             dbg_state_o;

    // clock / reset
    always #5 clk_i = ~clk_i;

    pad_mux_cfg_sequencer #(
        .N_IO(N_IO), .N_REQ(N_REQ), .SEL_W(SEL_W), .IDX_W(IDX_W),
        .SETTLE_CYCLES(SETTLE), .LOCK_MASK(48'h140)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_pad_i(req_pad_i), .req_sel_i(req_sel_i), .req_oe_i(req_oe_i),
        .pad_sel_o(pad_sel_o), .pad_oe_o(pad_oe_o),
        .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: expected pad state plus a timeline of scheduled updates.
    logic [N_IO-1:0]  lock_v;
    logic [SEL_W-1:0] m_sel [N_IO];
    logic             m_oe  [N_IO];
    int m_rr, m_free_at, m_err_at, m_busy_lo, m_busy_hi, last_grant;
    int ev_cyc[$], ev_pad[$], ev_kind[$], ev_val[$];

    function automatic logic [N_IO*SEL_W-1:0] exp_sel();
        logic [N_IO*SEL_W-1:0] v;
        for (int i = 0; i < N_IO; i++) v[i*SEL_W +: SEL_W] = m_sel[i];
        return v;
    endfunction

    function automatic logic [N_IO-1:0] exp_oe();
        logic [N_IO-1:0] v;
        for (int i = 0; i < N_IO; i++) v[i] = m_oe[i];
        return v;
    endfunction

    function automatic logic exp_busy();
        return (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
    endfunction

    function automatic logic exp_err();
        return (cyc == m_err_at);
    endfunction

    function automatic logic [N_REQ-1:0] exp_ready();
        logic [N_REQ-1:0] r;
        int k;
        r = '0;
        if (cyc >= m_free_at) begin
            for (int off = 0; off < N_REQ; off++) begin
                k = (m_rr + off) % N_REQ;
                if (r == '0 && req_valid_i[k]) r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_IO; i++) begin
            m_sel[i] = '0;
            m_oe[i]  = 1'b0;
        end
        m_rr = 0; m_free_at = cyc; m_err_at = -1;
        m_busy_lo = 1; m_busy_hi = 0; last_grant = -1;
        ev_cyc.delete(); ev_pad.delete(); ev_kind.delete(); ev_val.delete();
    endtask

    task automatic push_ev(input int c, input int pad, input int kind, input int val);
        ev_cyc.push_back(c); ev_pad.push_back(pad);
        ev_kind.push_back(kind); ev_val.push_back(val);
    endtask

    // Called with inputs settled, before the edge: decides what the edge accepts.
    task automatic model_commit();
        int g, pad, sel, oe;
        last_grant = -1;
        if (cyc < m_free_at) return;
        g = -1;
        for (int off = 0; off < N_REQ; off++)
            if (g < 0 && req_valid_i[(m_rr + off) % N_REQ]) g = (m_rr + off) % N_REQ;
        if (g < 0) return;
        last_grant = g;
        m_rr = (g + 1) % N_REQ;
        pad = int'(req_pad_i[g*IDX_W +: IDX_W]);
        sel = int'(req_sel_i[g*SEL_W +: SEL_W]);
        oe  = int'(req_oe_i[g]);
        if (pad >= N_IO) begin
            m_err_at = cyc + 1; m_free_at = cyc + 1;
        end else if (lock_v[pad]) begin
            m_err_at = cyc + 1; m_free_at = cyc + 1;
        end else if (sel == int'(m_sel[pad])) begin
            push_ev(cyc + 1, pad, 0, oe);
            m_free_at = cyc + 1;
        end else begin
            push_ev(cyc + 1, pad, 0, 0);
            push_ev(cyc + 1 + SETTLE, pad, 1, sel);
            push_ev(cyc + 2 + SETTLE, pad, 0, oe);
            m_busy_lo = cyc + 1; m_busy_hi = cyc + 1 + SETTLE;
            m_free_at = cyc + 2 + SETTLE;
        end
    endtask

    task automatic model_advance();
        for (int i = ev_cyc.size() - 1; i >= 0; i--) begin
            if (ev_cyc[i] == cyc) begin
                if (ev_kind[i] == 1) m_sel[ev_pad[i]] = SEL_W'(ev_val[i]);
                else                 m_oe[ev_pad[i]]  = ev_val[i][0];
                ev_cyc.delete(i); ev_pad.delete(i); ev_kind.delete(i); ev_val.delete(i);
            end
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        model_advance();
    endtask

    task automatic set_req(input int k, input int pad, input int sel, input int oe);
        req_valid_i[k] = 1'b1;
        req_pad_i[k*IDX_W +: IDX_W] = IDX_W'(pad);
        req_sel_i[k*SEL_W +: SEL_W] = SEL_W'(sel);
        req_oe_i[k] = oe[0];
    endtask

    // tests
    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (pad_sel_o !== '0) begin errors++; $display("FAIL reset_sel got %h want 0", pad_sel_o); end
        checks++; if (pad_oe_o !== '0) begin errors++; $display("FAIL reset_oe got %h want 0", pad_oe_o); end
        checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_flags busy %b err %b want 0 0", busy_o, err_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        model_reset();
        tick();
        checks++; if (pad_oe_o !== '0 || pad_sel_o !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle oe %h busy %b", pad_oe_o, busy_o); end
        checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL idle_ready got %b want 00", req_ready_o); end
    endtask

    task automatic test_full_path();
        // bring pad 10 to sel=0 oe=1 through the fast path
        set_req(1, 10, 0, 1);
        #1 model_commit();
        tick();
        req_valid_i = '0;
        checks++; if (pad_oe_o[10] !== 1'b1) begin errors++; $display("FAIL setup_oe10 got %b want 1", pad_oe_o[10]); end
        set_req(0, 10, 2, 1);
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL full_ready got %b want 01", req_ready_o); end
        model_commit();
        for (int n = 1; n <= 7; n++) begin
            tick();
            req_valid_i = '0;
            checks++;
            if (pad_oe_o[10] !== (n >= 6) || pad_sel_o[20 +: 2] !== ((n >= 5) ? 2'd2 : 2'd0)
                || busy_o !== (n <= 5)) begin
                errors++;
                $display("FAIL full_t%0d oe10 %b sel10 %0d busy %b", n, pad_oe_o[10], pad_sel_o[20 +: 2], busy_o);
            end
            checks++;
            if (pad_sel_o !== exp_sel() || pad_oe_o !== exp_oe()) begin
                errors++;
                $display("FAIL full_model_t%0d sel %h want %h oe %h want %h", n, pad_sel_o, exp_sel(), pad_oe_o, exp_oe());
            end
        end
    endtask

    task automatic test_fast_path();
        set_req(1, 10, 2, 0);
        #1;
        checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL fast_ready got %b want 10", req_ready_o); end
        model_commit();
        tick();
        req_valid_i = '0;
        checks++;
        if (pad_oe_o[10] !== 1'b0 || pad_sel_o[20 +: 2] !== 2'd2 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL fast_t1 oe10 %b sel10 %0d busy %b want 0 2 0", pad_oe_o[10], pad_sel_o[20 +: 2], busy_o);
        end
        tick();
        checks++; if (busy_o !== 1'b0 || pad_oe_o !== exp_oe() || pad_sel_o !== exp_sel()) begin errors++; $display("FAIL fast_t2 busy %b oe %h want %h", busy_o, pad_oe_o, exp_oe()); end
    endtask

    task automatic test_reject();
        logic [N_IO*SEL_W-1:0] s0;
        logic [N_IO-1:0]       o0;
        s0 = pad_sel_o; o0 = pad_oe_o;
        set_req(0, 6, 1, 1);
        #1 model_commit();
        tick();
        req_valid_i = '0;
        checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL rej_locked err %b busy %b want 1 0", err_o, busy_o); end
        // back to back: next accept possible in the pulse cycle
        set_req(1, 50, 3, 1);
        #1;
        checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL rej_b2b_ready got %b want 10", req_ready_o); end
        model_commit();
        tick();
        req_valid_i = '0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rej_range err %b want 1", err_o); end
        tick();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rej_pulse_end err %b want 0", err_o); end
        checks++; if (pad_sel_o !== s0 || pad_oe_o !== o0) begin errors++; $display("FAIL rej_unchanged sel %h want %h oe %h want %h", pad_sel_o, s0, pad_oe_o, o0); end
    endtask

    task automatic test_fairness();
        int grants[$];
        int pad;
        for (int k = 0; k < N_REQ; k++) begin
            do pad = $urandom_range(0, N_IO - 1); while (lock_v[pad]);
            set_req(k, pad, $urandom_range(0, 3), $urandom_range(0, 1));
        end
        for (int n = 0; n < 200 && grants.size() < 6; n++) begin
            #1;
            checks++; if (req_ready_o !== exp_ready()) begin errors++; $display("FAIL fair_ready got %b want %b", req_ready_o, exp_ready()); end
            checks++; if (busy_o === 1'b1 && req_ready_o !== '0) begin errors++; $display("FAIL fair_busy_ready got %b want 00", req_ready_o); end
            for (int k = 0; k < N_REQ; k++) if (req_ready_o[k]) grants.push_back(k);
            model_commit();
            tick();
            if (last_grant >= 0) begin
                do pad = $urandom_range(0, N_IO - 1); while (lock_v[pad]);
                set_req(last_grant, pad, $urandom_range(0, 3), $urandom_range(0, 1));
            end
            checks++; if (pad_sel_o !== exp_sel() || pad_oe_o !== exp_oe() || busy_o !== exp_busy()) begin errors++; $display("FAIL fair_outputs sel %h want %h oe %h want %h", pad_sel_o, exp_sel(), pad_oe_o, exp_oe()); end
        end
        req_valid_i = '0;
        checks++; if (grants.size() != 6) begin errors++; $display("FAIL fair_count got %0d want 6", grants.size()); end
        for (int i = 0; i < grants.size(); i++) begin
            checks++; if (grants[i] != i % N_REQ) begin errors++; $display("FAIL fair_order idx %0d got %0d want %0d", i, grants[i], i % N_REQ); end
        end
        // drain any in-flight sequence
        for (int n = 0; n < 10; n++) tick();
    endtask

    task automatic test_random();
        logic [N_REQ-1:0]      pending;
        logic [N_IO*SEL_W-1:0] ps;
        logic [N_IO-1:0]       po;
        int done, bad;
        pending = '0; done = 0;
        for (int n = 0; n < 4000 && done < 200; n++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!pending[k] && $urandom_range(0, 1) == 1) begin
                    set_req(k, $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 1));
                    pending[k] = 1'b1;
                end
            end
            #1;
            checks++; if (req_ready_o !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, req_ready_o, exp_ready()); end
            model_commit();
            ps = pad_sel_o; po = pad_oe_o;
            tick();
            if (last_grant >= 0) begin
                pending[last_grant] = 1'b0;
                req_valid_i[last_grant] = 1'b0;
                done++;
            end
            checks++;
            if (pad_sel_o !== exp_sel() || pad_oe_o !== exp_oe() || busy_o !== exp_busy() || err_o !== exp_err()) begin
                errors++;
                $display("FAIL rnd_outputs cyc %0d sel %h want %h oe %h want %h busy %b want %b err %b want %b",
                         cyc, pad_sel_o, exp_sel(), pad_oe_o, exp_oe(), busy_o, exp_busy(), err_o, exp_err());
            end
            bad = -1;
            for (int i = 0; i < N_IO; i++)
                if (pad_sel_o[i*SEL_W +: SEL_W] !== ps[i*SEL_W +: SEL_W] && (po[i] !== 1'b0 || pad_oe_o[i] !== 1'b0)) bad = i;
            checks++; if (bad >= 0) begin errors++; $display("FAIL rnd_glitch pad %0d sel changed with oe %b/%b want 0/0", bad, po[bad], pad_oe_o[bad]); end
        end
        req_valid_i = '0;
        checks++; if (done < 200) begin errors++; $display("FAIL rnd_budget accepted %0d want 200", done); end
        for (int n = 0; n < 10; n++) tick();
    endtask

    task automatic test_reset_mid();
        int sel;
        sel = (int'(m_sel[20]) + 1) % 4;
        set_req(0, 20, sel, 1);
        for (int n = 0; n < 20; n++) begin
            #1 model_commit();
            tick();
            if (last_grant >= 0) break;
        end
        req_valid_i = '0;
        tick();
        checks++; if (busy_o !== 1'b1 || pad_oe_o[20] !== 1'b0) begin errors++; $display("FAIL mid_settle busy %b oe20 %b want 1 0", busy_o, pad_oe_o[20]); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (pad_sel_o !== '0 || pad_oe_o !== '0) begin errors++; $display("FAIL mid_reset_pads sel %h oe %h want 0", pad_sel_o, pad_oe_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy_o); end
        @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        model_reset();
        for (int n = 0; n < SETTLE + 3; n++) tick();
        checks++; if (pad_sel_o !== '0 || pad_oe_o !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_no_resume sel %h oe %h busy %b", pad_sel_o, pad_oe_o, busy_o); end
        set_req(0, 3, 1, 1);
        set_req(1, 4, 1, 1);
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL mid_rr_reset got %b want 01", req_ready_o); end
        req_valid_i = '0;
    endtask

    initial begin
        lock_v = 48'h140;
        model_reset();
        test_reset();
        test_full_path();
        test_fast_path();
        test_reject();
        test_fairness();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
